// File: rtl/fhe_alu_pkg.sv
// Shared types of the butterfly ALU command port and state encoding.
package fhe_alu_pkg;

  parameter int unsigned FSIZE = 64;

  typedef enum logic [1:0] {
    COMMAND_NOP,
    COMMAND_BUTTER_P,
    COMMAND_BUTTER_W,
    COMMAND_BUTTER_A
  } command_e;

  localparam logic [FSIZE-1:0] STATE_IDLE    = '0;
  localparam logic [FSIZE-1:0] STATE_RUNNING = {{(FSIZE-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic             valid;
    command_e         command;
    logic [FSIZE-1:0] data0;
    logic [FSIZE-1:0] data1;
  } CommandDataPort;

endpackage

// File: rtl/fhe_butterfly_seq.sv
// Sequences one Cooley-Tukey NTT stage through the butterfly ALU: load modulus once,
// then per coefficient pair read a/b/W, issue W and A commands, wait for the ALU and
// write both results back in place. One butterfly in flight at a time.
module fhe_butterfly_seq
  import fhe_alu_pkg::*;
#(
  parameter int unsigned FSIZE = fhe_alu_pkg::FSIZE,
  parameter int unsigned N_LOG = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [FSIZE-1:0]  i_cfg_p,
  input  logic [FSIZE-1:0]  i_cfg_pinv,
  input  logic [N_LOG:0]    i_cfg_m,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [N_LOG-1:0]  o_coef_rd_addr,
  input  logic [FSIZE-1:0]  i_coef_rd_data,
  output logic              o_coef_wr_en,
  output logic [N_LOG-1:0]  o_coef_wr_addr,
  output logic [FSIZE-1:0]  o_coef_wr_data,
  output logic [N_LOG-1:0]  o_tw_rd_addr,
  input  logic [FSIZE-1:0]  i_tw_rd_data,
  output CommandDataPort    o_cmd,
  input  logic [FSIZE-1:0]  i_alu_state,
  input  logic [FSIZE-1:0]  i_alu_a_out,
  input  logic [FSIZE-1:0]  i_alu_b_out
);

  typedef enum logic [3:0] {
    StIdle,
    StSendP,
    StRdA,
    StRdB,
    StSendW,
    StSendA,
    StWaitRun,
    StWaitIdle,
    StWrA,
    StWrB,
    StDone,
    StErr
  } state_e;

  localparam logic [N_LOG:0]   M_ONE  = {{N_LOG{1'b0}}, 1'b1};
  // N/2 expressed in N_LOG+1 bits
  localparam logic [N_LOG:0]   M_MAX  = {2'b01, {(N_LOG-1){1'b0}}};
  localparam logic [N_LOG-1:0] A_ONE  = {{(N_LOG-1){1'b0}}, 1'b1};
  localparam logic [N_LOG-1:0] A_LAST = {N_LOG{1'b1}};

  state_e           r_state;
  state_e           w_state_next;
  logic [FSIZE-1:0] r_p;
  logic [FSIZE-1:0] r_pinv;
  logic [N_LOG-1:0] r_m;
  logic             r_err;
  logic [N_LOG-1:0] r_j;
  logic [N_LOG-1:0] r_base;
  logic [FSIZE-1:0] r_a;
  logic [FSIZE-1:0] r_b;
  logic [FSIZE-1:0] r_w;
  logic [FSIZE-1:0] r_a_out;
  logic [FSIZE-1:0] r_b_out;

  logic             w_m_legal;
  logic [N_LOG-1:0] w_i0;
  logic [N_LOG-1:0] w_i1;
  logic [N_LOG-1:0] w_tw;
  logic             w_last_pair;
  logic             w_last_j;
  logic             w_alu_idle;

  assign w_m_legal   = (i_cfg_m != '0) && ((i_cfg_m & (i_cfg_m - M_ONE)) == '0) &&
                       (i_cfg_m <= M_MAX);
  assign w_i0        = r_base + r_j;
  assign w_i1        = w_i0 + r_m;
  assign w_tw        = r_m + r_j;
  // i1 only reaches N-1 on the final pair of the stage
  assign w_last_pair = (w_i1 == A_LAST);
  assign w_last_j    = (r_j == (r_m - A_ONE));
  assign w_alu_idle  = (i_alu_state == STATE_IDLE);
  assign o_err       = r_err;

  // State register; reset aborts any stage in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (i_start) w_state_next = w_m_legal ? StSendP : StErr;
      StSendP:    w_state_next = StRdA;
      StRdA:      w_state_next = StRdB;
      StRdB:      w_state_next = StSendW;
      StSendW:    w_state_next = StSendA;
      StSendA:    w_state_next = StWaitRun;
      StWaitRun:  w_state_next = StWaitIdle;
      StWaitIdle: if (w_alu_idle) w_state_next = StWrA;
      StWrA:      w_state_next = StWrB;
      StWrB:      w_state_next = w_last_pair ? StDone : StRdA;
      StDone:     w_state_next = StIdle;
      StErr:      w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Config latch, pair counters and operand/result capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p     <= '0;
      r_pinv  <= '0;
      r_m     <= '0;
      r_err   <= 1'b0;
      r_j     <= '0;
      r_base  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_w     <= '0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_p    <= i_cfg_p;
            r_pinv <= i_cfg_pinv;
            r_m    <= i_cfg_m[N_LOG-1:0];
            r_err  <= ~w_m_legal;
            r_j    <= '0;
            r_base <= '0;
          end
        end
        StRdB: begin
          r_a <= i_coef_rd_data;
          r_w <= i_tw_rd_data;
        end
        StSendW: r_b <= i_coef_rd_data;
        StWaitIdle: begin
          if (w_alu_idle) begin
            r_a_out <= i_alu_a_out;
            r_b_out <= i_alu_b_out;
          end
        end
        StWrB: begin
          if (w_last_j) begin
            r_j    <= '0;
            r_base <= r_base + {r_m[N_LOG-2:0], 1'b0};
          end else begin
            r_j <= r_j + A_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: commands, RAM strobes and status
  always_comb begin
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_coef_rd_addr = '0;
    o_coef_wr_en   = 1'b0;
    o_coef_wr_addr = '0;
    o_coef_wr_data = '0;
    o_tw_rd_addr   = '0;
    o_cmd          = '0;
    case (r_state)
      StSendP: begin
        o_busy          = 1'b1;
        o_cmd.valid     = 1'b1;
        o_cmd.command   = COMMAND_BUTTER_P;
        o_cmd.data0     = r_p;
        o_cmd.data1     = r_pinv;
      end
      StRdA: begin
        o_busy         = 1'b1;
        o_coef_rd_addr = w_i0;
        o_tw_rd_addr   = w_tw;
      end
      StRdB: begin
        o_busy         = 1'b1;
        o_coef_rd_addr = w_i1;
      end
      StSendW: begin
        o_busy          = 1'b1;
        o_cmd.valid     = 1'b1;
        o_cmd.command   = COMMAND_BUTTER_W;
        o_cmd.data0     = r_w;
      end
      StSendA: begin
        o_busy          = 1'b1;
        o_cmd.valid     = 1'b1;
        o_cmd.command   = COMMAND_BUTTER_A;
        o_cmd.data0     = r_a;
        o_cmd.data1     = r_b;
      end
      StWaitRun, StWaitIdle: o_busy = 1'b1;
      StWrA: begin
        o_busy         = 1'b1;
        o_coef_wr_en   = 1'b1;
        o_coef_wr_addr = w_i0;
        o_coef_wr_data = r_a_out;
      end
      StWrB: begin
        o_busy         = 1'b1;
        o_coef_wr_en   = 1'b1;
        o_coef_wr_addr = w_i1;
        o_coef_wr_data = r_b_out;
      end
      StDone, StErr: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/fhe_butterfly_seq.md
Name: fhe_butterfly_seq

Overview:
Sequencer that runs one full Cooley-Tukey NTT stage through the butterfly ALU, which sits directly downstream of it. Per stage it loads the modulus once. For each coefficient pair it reads the pair and its twiddle from external single-port RAMs, issues the W and A commands on the ALU's CommandDataPort, waits for the ALU to return to idle, and writes a_out/b_out back in place. One butterfly is in flight at a time because the ALU is not pipelined across commands.

Parameters:
FSIZE, 64, coefficient/modulus width (from FHE_ALU_PKG)
N_LOG, 3, log2 of transform length N; RAM address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; launches a stage; ignored while busy=1
cfg_p  input  FSIZE  modulus p, sampled on start
cfg_pinv  input  FSIZE  Montgomery inverse, sampled on start
cfg_m  input  N_LOG+1  half-block length m, sampled on start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at stage end
err  output  1  set with done when cfg_m is illegal; cleared on next start
coef_rd_addr  output  N_LOG  coefficient RAM read address (1-cycle read latency)
coef_rd_data  input  FSIZE  coefficient read data
coef_wr_en  output  1  coefficient write strobe
coef_wr_addr  output  N_LOG  write address
coef_wr_data  output  FSIZE  write data
tw_rd_addr  output  N_LOG  twiddle ROM address (1-cycle latency)
tw_rd_data  input  FSIZE  twiddle data
cmd  output  CommandDataPort  to ALU commanddataport
alu_state  input  FSIZE  ALU stateport0
alu_a_out  input  FSIZE  ALU stateport1
alu_b_out  input  FSIZE  ALU stateport2

Behaviour:
- Reset: all outputs are 0 and cmd.valid=0. FSM goes to IDLE and all counters clear. Reset asserted in any state aborts the stage with no further writes.
- Legal m: a power of two with 1 <= m <= N/2. Any other value makes the block go IDLE->ERR: done=1, err=1 for one cycle, no commands, no RAM writes.
- Pair indexing: block k in 0..N/(2m)-1, j in 0..m-1.
  - i0 = 2mk+j, i1 = i0+m, twiddle address = m+j.
  - Order is j fastest, then k.
  - N/2 pairs per stage.
- FSM:
  - IDLE: on start, latch cfg_*, clear err, go to SEND_P.
  - SEND_P: cmd.valid=1, command=COMMAND_BUTTER_P, data0=p, data1=pInv. Go to RD_A.
  - RD_A: coef_rd_addr=i0, tw_rd_addr=m+j. Go to RD_B.
  - RD_B: capture a=coef_rd_data and W=tw_rd_data; coef_rd_addr=i1. Go to SEND_W.
  - SEND_W: capture b=coef_rd_data; cmd COMMAND_BUTTER_W with data0=W. Go to SEND_A.
  - SEND_A: cmd COMMAND_BUTTER_A with data0=a, data1=b. Go to WAIT_RUN.
  - WAIT_RUN: fixed 1 cycle, covering the ALU's registered state update. Go to WAIT_IDLE.
  - WAIT_IDLE: hold until alu_state==STATE_IDLE, with no timeout. alu_a_out/alu_b_out are final in that cycle; capture both. Go to WR_A.
  - WR_A: coef_wr_en=1, addr=i0, data=captured a_out.
  - WR_B: coef_wr_en=1, addr=i1, data=captured b_out. Advance j/k. If this was the last pair go to DONE, else go to RD_A.
  - DONE: done=1 for one cycle, busy drops. Go to IDLE.
- cmd.valid is high only in SEND_P, SEND_W and SEND_A. In those cycles, data fields not named above are 0.
- At most one of read or write happens per cycle; the RAM is single-port safe.
- Per-pair cycle count is 6 + ALU latency.
- start asserted in DONE or ERR is ignored; it is accepted only in IDLE.

Test Plan:
- Reset: hold rst mid-cycle with start=1 -> asynchronous clear; busy=done=err=coef_wr_en=cmd.valid=0; no commands after release.
- Stage m=4, N=8, p=17, pinv=15, coef[i]=10*i, tw[t]=t. Use a stub ALU that goes RUNNING for 5 cycles then IDLE with a_out=a+1, b_out=b+2.
  - Commands: P(17,15), then W(4) A(0,40).
  - Writes in address order 0,4,1,5,2,6,3,7 with data 1,42,11,52,21,62,31,72.
  - done pulses exactly once.
- Stage m=1, same setup: twiddle address is always 1; pairs (0,1),(2,3),(4,5),(6,7); 8 writes; done once.
- Illegal cfg_m=0, then cfg_m=3, then cfg_m=8 -> each gives done=err=1 one cycle after start; zero commands; zero writes. A following legal start clears err.
- Stub ALU holds RUNNING for 40 cycles -> no write and no new command until alu_state returns to idle; then WR_A follows within 1 cycle.
- rst asserted during WAIT_IDLE of pair 2 -> no further writes; a fresh start reruns from pair 0 and emits a P command first.
